lmem_arbiter: RTL
=================

LMEM_ARBITER -- requirements
Module: lmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, layer-memory address width.
REQ-002 Parameter DATA_W, default 13, layer-memory data width.
REQ-003 Parameter MAX_BURST, default 64, maximum consecutive locked grants to one requester.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req[1:0]  input  2  per-requester access request (index 0 = conv/ReLU writer, 1 = pooling engine).
REQ-007 we[1:0]  input  2  per-requester 1 = write, 0 = read.
REQ-008 sel[1:0]  input  2  per-requester layer select (0 = layer 0, 1 = layer 1).
REQ-009 lock[1:0]  input  2  per-requester burst-lock hint.
REQ-010 addr0, addr1  input  ADDR_W each  per-requester address.
REQ-011 wdata0, wdata1  input  DATA_W each  per-requester write data.
REQ-012 gnt[1:0]  output  2  one-cycle grant pulse; request accepted this cycle.
REQ-013 rvalid[1:0]  output  2  read data valid for that requester.
REQ-014 rdata  output  DATA_W  read data, shared by both requesters.
REQ-015 cwr, crd, csel  output  1 each  memory write strobe, read strobe, layer select.
REQ-016 caddr_wr, caddr_rd  output  ADDR_W each  memory write/read address.
REQ-017 cdata_wr  output  DATA_W  memory write data.
REQ-018 cdata_rd  input  DATA_W  memory read data, valid the cycle after crd is sampled high.
REQ-019 idle  output  1  high when no access is in flight and no request is pending.

Function
REQ-020 Requesters hold req/we/sel/addr/wdata stable until their gnt pulse; gnt is combinational from req and arbiter state, at most one bit high per cycle.
REQ-021 Arbitration is round-robin: on contention the requester not granted most recently wins; a sole requester is granted every cycle.
REQ-022 If the last-granted requester has lock high and req high, it keeps priority, limited by a burst counter of MAX_BURST consecutive grants.
REQ-023 When the burst counter reaches MAX_BURST and the other requester is requesting, priority moves to the other requester and the counter clears; with no competitor, granting continues and the counter saturates.
REQ-024 A grant in cycle t drives the access on memory outputs in cycle t+1 for exactly one cycle: cwr=we, crd=~we, csel=sel, and caddr_wr+cdata_wr or caddr_rd.
REQ-025 Cycles with no grant drive cwr=0 and crd=0 in the following cycle; csel, addresses and cdata_wr hold their last values.
REQ-026 For a read granted at t, rvalid of that requester pulses in t+2; rdata equals cdata_rd in that cycle.
REQ-027 Back-to-back reads from alternating requesters are supported; a 2-entry owner pipeline tags each return with the correct requester.
REQ-028 idle = ~|req & ~cwr & ~crd & no read return pending.
REQ-029 Requests deasserted without a grant are dropped silently; no state changes.

Reset
REQ-030 While reset is low: gnt=0, rvalid=0, cwr=0, crd=0, csel=0, caddr_wr=0, caddr_rd=0, cdata_wr=0, idle=1, priority = requester 0, burst counter = 0.
REQ-031 Reset mid-operation discards in-flight reads; no rvalid is produced for them after release.

Structure
REQ-032 ADDR_W, DATA_W, MAX_BURST defaults and the requester index constants (REQ_CONV=0, REQ_POOL=1) live in the shared layer-memory package.
REQ-033 One sub-module, lmem_rr_arb: 2-way round-robin priority with lock and burst counter; the top handles memory output registers and the read-return pipeline.

Verification
REQ-034 req0 write sel=0 addr=0x005 wdata=0x0123 alone -> gnt[0] in cycle t; cwr=1, csel=0, caddr_wr=0x005, cdata_wr=0x0123 in t+1.
REQ-035 Both requesting continuously, lock=0 -> gnt alternates 0,1,0,1...; no cycle with cwr and crd both high.
REQ-036 req0 lock=1 streaming writes, req1 requesting from the first cycle -> 64 consecutive gnt[0], then gnt[1], with MAX_BURST=64.
REQ-037 req1 read addr=0x3FF with memory returning 0x0A5A -> crd=1, caddr_rd=0x3FF in t+1; rvalid[1]=1, rdata=0x0A5A in t+2.
REQ-038 Read granted at t, reset asserted at t+1, released at t+3 -> no rvalid pulse; all outputs at reset values; idle=1.

Source files
------------

// File: rtl/lmem_pkg.sv
// Shared layer-memory constants: default widths, burst limit and requester indices.
package lmem_pkg;
  localparam int LMEM_ADDR_W    = 12;
  localparam int LMEM_DATA_W    = 13;
  localparam int LMEM_MAX_BURST = 64;

  localparam int REQ_CONV = 0;
  localparam int REQ_POOL = 1;
endpackage

// File: rtl/lmem_rr_arb.sv
// Two-way round-robin arbiter with burst-lock priority bounded by a saturating burst counter.
module lmem_rr_arb
  import lmem_pkg::*;
#(
  parameter int MAX_BURST = LMEM_MAX_BURST
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  logic             last_q, last_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             hold;
  logic             win;
  logic [1:0]       gnt_raw;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= CNT_MAX) return CNT_MAX;
    else return v + 1'b1;
  endfunction

  // burst_q counts consecutive grants to last_q; zero only before the first grant
  // after reset, so a stale last_q cannot claim lock priority out of reset.
  always_comb begin
    gnt_raw = 2'b00;
    last_d  = last_q;
    burst_d = burst_q;
    hold    = (burst_q != '0) && (burst_q < CNT_MAX) && lock[last_q];
    if (req == 2'b11) win = hold ? last_q : ~last_q;
    else              win = req[1];
    if (|req) begin
      gnt_raw[win] = 1'b1;
      last_d       = win;
      burst_d      = (win == last_q) ? sat_inc(burst_q) : CNT_W'(1);
    end
  end

  assign gnt = reset ? gnt_raw : 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q  <= 1'b1;
      burst_q <= '0;
    end else begin
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/lmem_arbiter.sv
// Layer-memory arbiter: grants one of two requesters per cycle, registers the memory
// strobes/addresses for the following cycle and tags read returns with their owner.
module lmem_arbiter
  import lmem_pkg::*;
#(
  parameter int ADDR_W    = LMEM_ADDR_W,
  parameter int DATA_W    = LMEM_DATA_W,
  parameter int MAX_BURST = LMEM_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [1:0]        sel,
  input  logic [1:0]        lock,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              cwr,
  output logic              crd,
  output logic              csel,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic [DATA_W-1:0] cdata_wr,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              idle
);

  logic              g_id, g_vld, g_we, g_sel;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  logic              cwr_q, cwr_d, crd_q, crd_d, csel_q, csel_d;
  logic [ADDR_W-1:0] caddr_wr_q, caddr_wr_d, caddr_rd_q, caddr_rd_d;
  logic [DATA_W-1:0] cdata_wr_q, cdata_wr_d;
  logic              rd_own_p1_q, rd_own_p1_d;
  logic              rd_vld_p2_q, rd_vld_p2_d, rd_own_p2_q, rd_own_p2_d;

  lmem_rr_arb #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .gnt   (gnt)
  );

  // Stage p0: mux the granted requester's access onto the memory output registers.
  always_comb begin
    g_vld   = |gnt;
    g_id    = gnt[REQ_POOL];
    g_we    = g_id ? we[REQ_POOL]  : we[REQ_CONV];
    g_sel   = g_id ? sel[REQ_POOL] : sel[REQ_CONV];
    g_addr  = g_id ? addr1  : addr0;
    g_wdata = g_id ? wdata1 : wdata0;

    cwr_d      = g_vld & g_we;
    crd_d      = g_vld & ~g_we;
    csel_d     = g_vld ? g_sel : csel_q;
    caddr_wr_d = (g_vld & g_we)  ? g_addr  : caddr_wr_q;
    cdata_wr_d = (g_vld & g_we)  ? g_wdata : cdata_wr_q;
    caddr_rd_d = (g_vld & ~g_we) ? g_addr  : caddr_rd_q;
    // Stage p1 -> p2: crd_q marks the read in flight, the owner follows it one cycle on.
    rd_own_p1_d = g_id;
    rd_vld_p2_d = crd_q;
    rd_own_p2_d = rd_own_p1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cwr_q       <= 1'b0;
      crd_q       <= 1'b0;
      csel_q      <= 1'b0;
      caddr_wr_q  <= '0;
      caddr_rd_q  <= '0;
      cdata_wr_q  <= '0;
      rd_own_p1_q <= 1'b0;
      rd_vld_p2_q <= 1'b0;
      rd_own_p2_q <= 1'b0;
    end else begin
      cwr_q       <= cwr_d;
      crd_q       <= crd_d;
      csel_q      <= csel_d;
      caddr_wr_q  <= caddr_wr_d;
      caddr_rd_q  <= caddr_rd_d;
      cdata_wr_q  <= cdata_wr_d;
      rd_own_p1_q <= rd_own_p1_d;
      rd_vld_p2_q <= rd_vld_p2_d;
      rd_own_p2_q <= rd_own_p2_d;
    end
  end

  // Stage p2: memory data arrives this cycle and is forwarded to its owner.
  assign rvalid   = {rd_vld_p2_q & rd_own_p2_q, rd_vld_p2_q & ~rd_own_p2_q};
  assign rdata    = cdata_rd;
  assign cwr      = cwr_q;
  assign crd      = crd_q;
  assign csel     = csel_q;
  assign caddr_wr = caddr_wr_q;
  assign caddr_rd = caddr_rd_q;
  assign cdata_wr = cdata_wr_q;
  assign idle     = ~reset | (~|req & ~cwr_q & ~crd_q & ~rd_vld_p2_q);

endmodule
